// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter for a single-cycle core: stores fill a byte
// FIFO, a baud-timed serializer drains it onto tx; reads are combinational.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = CW - 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   baud_div;

  state_t        state, state_d;
  logic [7:0]    shift, shift_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [15:0]   baud_cnt, baud_cnt_d;
  logic [15:0]   div_q, div_d;
  logic          tx_d;
  logic          pop, start_frame;

  logic          wr_en, push, accept, full, empty;
  logic [31:0]   status;
  logic          unused;

  assign Hit    = (Addr[31:4] == BASE_ADDR[31:4]);
  assign wr_en  = MemWrite && Hit;
  assign push   = wr_en && (Addr[3:2] == 2'd0);
  assign full   = (count == CW'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign accept = push && (!full || pop);
  assign unused = ^{Addr[1:0], WriteData[31:16]};

  always_comb begin
    status          = '0;
    status[0]       = (state != IDLE);
    status[1]       = full;
    status[2]       = empty;
    status[3]       = overflow;
    status[8 +: CW] = count;
  end

  always_comb begin
    ReadData = '0;
    if (Hit) begin
      case (Addr[3:2])
        2'd1:    ReadData = status;
        2'd2:    ReadData = {16'b0, baud_div};
        default: ReadData = '0;
      endcase
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state;
    shift_d     = shift;
    bit_idx_d   = bit_idx;
    baud_cnt_d  = baud_cnt;
    div_d       = div_q;
    start_frame = 1'b0;
    case (state)
      IDLE:  start_frame = !empty;
      START: begin
        if (baud_cnt == '0) begin
          state_d    = DATA;
          bit_idx_d  = '0;
          baud_cnt_d = div_q - 16'd1;
        end else begin
          baud_cnt_d = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_cnt_d = div_q - 16'd1;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            shift_d   = shift >> 1;
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt - 16'd1;
        end
      end
      STOP: begin
        if (baud_cnt == '0) begin
          start_frame = !empty;
          state_d     = IDLE;
        end else begin
          baud_cnt_d = baud_cnt - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Divider is sampled only here, so a mid-frame BAUDDIV write waits for the next frame.
    if (start_frame) begin
      state_d    = START;
      shift_d    = mem[rd_ptr];
      div_d      = baud_div;
      baud_cnt_d = baud_div - 16'd1;
    end
    pop  = start_frame;
    tx_d = (state_d == START) ? 1'b0 :
           (state_d == DATA)  ? shift_d[0] : 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      div_q    <= DEFAULT_DIV;
      tx       <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      baud_div <= DEFAULT_DIV;
    end else begin
      state    <= state_d;
      shift    <= shift_d;
      bit_idx  <= bit_idx_d;
      baud_cnt <= baud_cnt_d;
      div_q    <= div_d;
      tx       <= tx_d;
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !accept)
        overflow <= 1'b1;
      else if (wr_en && (Addr[3:2] == 2'd1) && WriteData[3])
        overflow <= 1'b0;
      if (wr_en && (Addr[3:2] == 2'd2))
        baud_div <= (WriteData[15:0] == 16'd0) ? 16'd1 : WriteData[15:0];
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count and pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= WriteData[7:0];
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: register access, 8N1 waveforms against a
// frame model, back-to-back frames, FIFO overflow, reset flush and address decode.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] ReadData;
  logic        Hit;
  logic        tx;

  int   total = 0;
  int   bad = 0;
  logic rec = 1'b0;
  logic wave[$];

  uart_tx_mmio #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .DEFAULT_DIV(16'd434)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Addr     (Addr),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .ReadData (ReadData),
    .Hit      (Hit),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  // One tx sample per clock, taken just after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (rec) wave.push_back(tx);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_word(input int busy, input int full, input int empty,
                                              input int ov, input int cnt);
    return 32'(cnt * 256 + ov * 8 + empty * 4 + full * 2 + busy);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr      = a;
    WriteData = d;
    MemWrite  = 1'b1;
    @(negedge clk);
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Addr     = a;
    MemWrite = 1'b0;
    #1;
    d = ReadData;
  endtask

  // Sample 0 is the idle line after the write edge; then 10*div samples per byte
  // (start 0, data LSB first, stop 1); everything after is idle high.
  task automatic check_wave(input string tag, input byte_q_t bytes, input int div);
    int   per;
    int   n;
    int   mis;
    logic e;
    per = 10 * div;
    n   = bytes.size();
    mis = 0;
    for (int i = 0; i < wave.size(); i++) begin
      e = 1'b1;
      if (i >= 1 && (i - 1) < n * per) begin
        int f;
        int b;
        f = (i - 1) / per;
        b = ((i - 1) % per) / div;
        if (b == 0)      e = 1'b0;
        else if (b <= 8) e = bytes[f][b-1];
      end
      if (wave[i] !== e) mis++;
    end
    check({tag, "_len"}, 32'(wave.size() >= 1 + n * per), 32'd1);
    check(tag, 32'(mis), 32'd0);
    wave.delete();
  endtask

  initial begin
    logic [31:0] r;
    byte_q_t     q;
    int          div;
    logic [7:0]  b;

    cyc(2);
    reset = 1'b0;
    rd(BASE + 32'h4, r); check("rst_status", r, status_word(0, 0, 1, 0, 0));
    rd(BASE + 32'h8, r); check("rst_div", r, 32'd434);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_hit", 32'(Hit), 32'd1);

    // Single 0xA5 frame at DIV=4
    wr(BASE + 32'h8, 32'd4);
    rd(BASE + 32'h8, r); check("div4_rd", r, 32'd4);
    rec = 1'b1;
    wr(BASE, 32'hA5);
    check("a5_tx_pre", 32'(tx), 32'd1);
    cyc(1); check("a5_tx_fall", 32'(tx), 32'd0);
    rd(BASE + 32'h4, r); check("a5_busy_start", r, status_word(1, 0, 1, 0, 0));
    cyc(39);
    rd(BASE + 32'h4, r); check("a5_busy_last", r, status_word(1, 0, 1, 0, 0));
    cyc(1);
    rd(BASE + 32'h4, r); check("a5_idle", r, status_word(0, 0, 1, 0, 0));
    cyc(2);
    rec = 1'b0;
    q = '{8'hA5};
    check_wave("a5_wave", q, 4);

    // Three contiguous frames at DIV=2
    wr(BASE + 32'h8, 32'd2);
    q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    rec = 1'b1;
    wr(BASE, 32'(q[0]));
    wr(BASE, 32'(q[1]));
    wr(BASE, 32'(q[2]));
    rd(BASE + 32'h4, r); check("b2b_cnt2", r, status_word(1, 0, 0, 0, 2));
    cyc(19);
    rd(BASE + 32'h4, r); check("b2b_cnt1", r, status_word(1, 0, 0, 0, 1));
    cyc(20);
    rd(BASE + 32'h4, r); check("b2b_cnt0", r, status_word(1, 0, 1, 0, 0));
    cyc(19);
    rd(BASE + 32'h4, r); check("b2b_busy_last", r, status_word(1, 0, 1, 0, 0));
    cyc(1);
    rd(BASE + 32'h4, r); check("b2b_idle", r, status_word(0, 0, 1, 0, 0));
    cyc(2);
    rec = 1'b0;
    check_wave("b2b_wave", q, 2);

    // Random single frames, first one at DIV=1
    for (int k = 0; k < 4; k++) begin
      div = (k == 0) ? 1 : int'($urandom_range(1, 6));
      wr(BASE + 32'h8, 32'(div));
      b = 8'($urandom);
      q = '{b};
      rec = 1'b1;
      wr(BASE, 32'(b));
      cyc(10 * div + 2);
      rec = 1'b0;
      check_wave($sformatf("rand_wave%0d", k), q, div);
    end

    // BAUDDIV rewritten mid-frame applies only to the next frame
    wr(BASE + 32'h8, 32'd3);
    q = '{8'($urandom)};
    rec = 1'b1;
    wr(BASE, 32'(q[0]));
    cyc(5);
    wr(BASE + 32'h8, 32'd5);
    cyc(26);
    rec = 1'b0;
    check_wave("middiv_wave", q, 3);
    rd(BASE + 32'h8, r); check("middiv_rd", r, 32'd5);

    // Overflow: first write pops at once, so 17 writes fill all 16 entries
    wr(BASE + 32'h8, 32'd100);
    for (int i = 0; i < 17; i++) wr(BASE, $urandom);
    rd(BASE + 32'h4, r); check("ovf_full", r, status_word(1, 1, 0, 0, DEPTH));
    wr(BASE, $urandom);
    rd(BASE + 32'h4, r); check("ovf_set", r, status_word(1, 1, 0, 1, DEPTH));
    wr(BASE + 32'h4, 32'h0000_0007);
    rd(BASE + 32'h4, r); check("ovf_keep", r, status_word(1, 1, 0, 1, DEPTH));
    wr(BASE + 32'h4, 32'h0000_0008);
    rd(BASE + 32'h4, r); check("ovf_clear", r, status_word(1, 1, 0, 0, DEPTH));
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    rd(BASE + 32'h4, r); check("flush_status", r, status_word(0, 0, 1, 0, 0));
    rd(BASE + 32'h8, r); check("flush_div", r, 32'd434);

    // Reset in the middle of data bit 3
    wr(BASE + 32'h8, 32'd4);
    wr(BASE, 32'h0000_00F0);
    cyc(18);
    rd(BASE + 32'h4, r); check("mid_busy", r, status_word(1, 0, 1, 0, 0));
    reset = 1'b1;
    cyc(1);
    check("mid_tx", 32'(tx), 32'd1);
    rd(BASE + 32'h4, r); check("mid_status", r, status_word(0, 0, 1, 0, 0));
    reset = 1'b0;
    rec = 1'b1;
    cyc(30);
    rec = 1'b0;
    q = {};
    check_wave("mid_quiet", q, 4);

    // Address decode and BAUDDIV zero handling
    wr(BASE + 32'h8, 32'd0);
    rd(BASE + 32'h8, r); check("div0_rd", r, 32'd1);
    rd(BASE + 32'hA, r); check("div_alias", r, 32'd1);
    rd(BASE + 32'h10, r); check("miss_rd", r, 32'd0);
    check("miss_hit", 32'(Hit), 32'd0);
    wr(BASE + 32'h18, 32'd77);
    rd(BASE + 32'h8, r); check("miss_div_kept", r, 32'd1);
    wr(BASE + 32'h10, 32'h55);
    rd(BASE + 32'h4, r); check("miss_no_push", r, status_word(0, 0, 1, 0, 0));
    cyc(2);
    check("miss_tx_idle", 32'(tx), 32'd1);
    rd(BASE, r); check("txdata_rd", r, 32'd0);
    rd(BASE + 32'hC, r); check("rsvd_rd", r, 32'd0);
    wr(BASE + 32'hC, 32'hFFFF_FFFF);
    rd(BASE + 32'h8, r); check("rsvd_wr_ignored", r, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
